// File: rtl/mem_port_req_ctrl_pkg.sv
// Shared types and constants for the memory-port request controller.
// rsp_t / pipe_t describe the default-width layouts; the top re-declares
// them at its own parameter widths so non-default instances stay legal.
package mem_port_pkg;

   localparam int unsigned DEF_WIDTH      = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 3;

   // One response FIFO entry.
   typedef struct packed {
      logic [DEF_WIDTH-1:0]      data;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic                      we;
   } rsp_t;

   // One read-tracking pipeline stage.
   typedef struct packed {
      logic                      valid;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic                      is_write;
   } pipe_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/mem_port_req_ctrl_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for response entries.
// Head entry is presented combinationally while the FIFO is non-empty.
module rsp_fifo
   import mem_port_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = rsp_t
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  T                       i_push_data,
   input  logic                   i_pop,
   output T                       o_pop_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PW       = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_pop     = i_pop & ~o_empty;
   assign do_push    = i_push & (~o_full | do_pop);
   assign o_empty    = (count == '0);
   assign o_full     = (count == FULL_CNT);
   assign o_count    = count;
   assign o_pop_data = o_empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because the head is masked when empty.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_push_data;
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Overflow guard: the upstream credit scheme must never let this happen.
   always_ff @(posedge i_clk) begin
      if (!i_rst) assert (!(i_push && o_full && !i_pop)) else $error("rsp_fifo: push to full FIFO");
   end

endmodule

// File: rtl/mem_port_req_ctrl.sv
// Single-port request controller for one port of the latency memory.
// Issues requests to the memory port, tracks reads through READ_LATENCY
// and returns data through a credit-protected FWFT response FIFO.
// Optional macro WRITE_ACK_EN: writes consume a credit and return an
// acknowledge response with o_rsp_we = 1.
module mem_port_req_ctrl
   import mem_port_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int unsigned READ_LATENCY  = 5,
   parameter int unsigned WRITE_LATENCY = 4,
   parameter int unsigned RSP_DEPTH     = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic                         i_req_we,
   input  logic [ADDR_WIDTH-1:0]        i_req_addr,
   input  logic [WIDTH-1:0]             i_req_din,
   output logic                         o_mem_en,
   output logic                         o_mem_we,
   output logic [ADDR_WIDTH-1:0]        o_mem_addr,
   output logic [WIDTH-1:0]             o_mem_din,
   input  logic [WIDTH-1:0]             i_mem_dout,
   output logic                         o_rsp_valid,
   input  logic                         i_rsp_ready,
   output logic [WIDTH-1:0]             o_rsp_data,
   output logic [ADDR_WIDTH-1:0]        o_rsp_addr,
   output logic                         o_rsp_we,
   output logic [$clog2(RSP_DEPTH):0]   o_credits
);

   localparam int unsigned CW           = $clog2(RSP_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CREDITS = CW'(RSP_DEPTH);

   if (READ_LATENCY < 1) begin : g_chk_rl
      $error("mem_port_req_ctrl: READ_LATENCY must be >= 1");
   end
   if (WRITE_LATENCY > READ_LATENCY) begin : g_chk_wl
      $error("mem_port_req_ctrl: WRITE_LATENCY must not exceed READ_LATENCY");
   end
   if (!is_pow2(RSP_DEPTH) || RSP_DEPTH < 2) begin : g_chk_depth
      $error("mem_port_req_ctrl: RSP_DEPTH must be a power of 2 and >= 2");
   end

   typedef struct packed {
      logic [WIDTH-1:0]      data;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
   } rsp_w_t;

`ifdef WRITE_ACK_EN
   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  is_write;
   } pipe_w_t;
`else
   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
   } pipe_w_t;
`endif

   logic [CW-1:0] credits;
   logic [CW-1:0] fifo_count;
   logic          accept;
   logic          consume;
   logic          pop;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   pipe_w_t       pipe [READ_LATENCY];
   rsp_w_t        push_data;
   rsp_w_t        head;

   // Request side: ready only depends on credits, everything is held low in reset.
   assign o_req_ready = ~i_rst & (credits != '0);
   assign accept      = i_req_valid & o_req_ready;
   assign o_mem_en    = accept;
   assign o_mem_we    = i_rst ? 1'b0 : i_req_we;
   assign o_mem_addr  = i_rst ? '0 : i_req_addr;
   assign o_mem_din   = i_rst ? '0 : i_req_din;

`ifdef WRITE_ACK_EN
   assign consume = accept;
`else
   assign consume = accept & ~i_req_we;
`endif

   // Response side outputs, masked while in reset or empty.
   assign o_rsp_valid = ~i_rst & ~fifo_empty;
   assign pop         = o_rsp_valid & i_rsp_ready;
   assign o_rsp_data  = o_rsp_valid ? head.data : '0;
   assign o_rsp_addr  = o_rsp_valid ? head.addr : '0;
`ifdef WRITE_ACK_EN
   assign o_rsp_we    = o_rsp_valid & head.we;
`else
   assign o_rsp_we    = 1'b0;
`endif
   assign o_credits   = i_rst ? FULL_CREDITS : credits;

   // Credit counter: one slot reserved per tracked request, freed on pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         credits <= FULL_CREDITS;
      end else begin
         case ({consume, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   // Latency pipeline: stage 0 captures the accepted request at the issue edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0].valid <= consume;
         pipe[0].addr  <= i_req_addr;
`ifdef WRITE_ACK_EN
         pipe[0].is_write <= i_req_we;
`endif
         for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The last stage lines up with the memory's read data for the same request.
   assign push = pipe[READ_LATENCY-1].valid;

   // Build the FIFO entry from the last pipeline stage and the memory output.
   always_comb begin
      push_data      = '0;
      push_data.addr = pipe[READ_LATENCY-1].addr;
`ifdef WRITE_ACK_EN
      push_data.we   = pipe[READ_LATENCY-1].is_write;
      push_data.data = pipe[READ_LATENCY-1].is_write ? '0 : i_mem_dout;
`else
      push_data.data = i_mem_dout;
`endif
   end

   rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .T     (rsp_w_t)
   ) u_rsp_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push),
      .i_push_data (push_data),
      .i_pop       (pop),
      .o_pop_data  (head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (fifo_count)
   );

   // Credit bookkeeping invariants.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(consume && credits == '0)) else $error("mem_port_req_ctrl: credit underflow");
         assert (!(pop && !consume && credits == FULL_CREDITS)) else $error("mem_port_req_ctrl: credit overflow");
         assert (credits <= FULL_CREDITS) else $error("mem_port_req_ctrl: credits out of range");
         assert (int'(fifo_count) + int'(credits) <= int'(RSP_DEPTH)) else $error("mem_port_req_ctrl: occupancy exceeds credit budget");
         assert (!(push && fifo_full && !pop)) else $error("mem_port_req_ctrl: response FIFO overflow");
`ifndef WRITE_ACK_EN
         assert (!(o_rsp_valid && head.we)) else $error("mem_port_req_ctrl: write acknowledge without WRITE_ACK_EN");
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_req_ctrl.sv
// Self-checking bench for mem_port_req_ctrl with a behavioural latency memory
// and an in-order response scoreboard.
module tb_mem_port_req_ctrl;

   localparam int unsigned W     = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned RL    = 5;
   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [W-1:0]  req_din = '0;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_din;
   logic [W-1:0]  mem_dout;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          rsp_we;
   logic [3:0]    credits;

   int total = 0;
   int bad   = 0;
   int n_rsp = 0;

   typedef struct {
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic          w;
   } exp_t;

   exp_t         sb [$];
   exp_t         e;
   logic [W-1:0] ref_mem [1 << AW];
   logic [W-1:0] mem_arr [1 << AW];
   logic [W-1:0] dly     [RL];

   always #5 clk = ~clk;

   mem_port_req_ctrl #(
      .WIDTH         (W),
      .ADDR_WIDTH    (AW),
      .READ_LATENCY  (RL),
      .WRITE_LATENCY (4),
      .RSP_DEPTH     (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_din   (req_din),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_din   (mem_din),
      .i_mem_dout  (mem_dout),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_data  (rsp_data),
      .o_rsp_addr  (rsp_addr),
      .o_rsp_we    (rsp_we),
      .o_credits   (credits)
   );

   // Behavioural memory: read data emerges RL edges after the enable edge.
   assign mem_dout = dly[RL-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] <= mem_din;
         dly[0] <= mem_arr[mem_addr];
      end else begin
         dly[0] <= 8'hA5;
      end
      for (int k = 1; k < RL; k++) dly[k] <= dly[k-1];
   end

   // Scoreboard monitor: credit model, expected push on accept, compare on pop.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         total++;
         if (int'(credits) !== int'(DEPTH) - sb.size()) begin
            bad++;
            $display("FAIL credits_model got=%0d expected=%0d", credits, int'(DEPTH) - sb.size());
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected got data=%0d addr=%0d we=%0d expected no response", rsp_data, rsp_addr, rsp_we);
            end else begin
               e = sb.pop_front();
               if ({rsp_data, rsp_addr, rsp_we} !== {e.d, e.a, e.w}) begin
                  bad++;
                  $display("FAIL rsp_order got data=%0d addr=%0d we=%0d expected data=%0d addr=%0d we=%0d",
                           rsp_data, rsp_addr, rsp_we, e.d, e.a, e.w);
               end
            end
         end
         if (req_valid && req_ready) begin
            if (req_we) begin
               ref_mem[req_addr] = req_din;
`ifdef WRITE_ACK_EN
               sb.push_back('{d: '0, a: req_addr, w: 1'b1});
`endif
            end else begin
               sb.push_back('{d: ref_mem[req_addr], a: req_addr, w: 1'b0});
            end
         end
      end
   end

   task automatic drive_idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_din   = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_din = 8'h77;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({req_ready, mem_en, mem_we, mem_addr, mem_din, rsp_valid, rsp_data, rsp_addr, rsp_we} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got rdy=%0b en=%0b we=%0b addr=%0d din=%0d rv=%0b expected all zero",
                  req_ready, mem_en, mem_we, mem_addr, mem_din, rsp_valid);
      end
      total++;
      if (credits !== 4'd8) begin bad++; $display("FAIL reset_credits got=%0d expected=8", credits); end
      @(posedge clk); #1;
      drive_idle();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%0b expected=1", req_ready); end
      total++;
      if (mem_en !== 1'b0) begin bad++; $display("FAIL idle_mem_en got=%0b expected=0", mem_en); end
   endtask

   task automatic test_write_read();
      logic          we_s  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [AW-1:0] adr_s [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
      logic [W-1:0]  din_s [5] = '{8'd12, 8'd13, 8'd0, 8'd0, 8'd0};
      logic [W-1:0]  exp_d [3] = '{8'd12, 8'd13, 8'd12};
      logic [AW-1:0] exp_a [3] = '{3'd0, 3'd1, 3'd0};
      logic          exp_v;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = we_s[i]; req_addr = adr_s[i]; req_din = din_s[i];
         @(negedge clk);
         total++;
         if (mem_en !== 1'b1) begin bad++; $display("FAIL wr_rd_mem_en[%0d] got=%0b expected=1", i, mem_en); end
      end
      @(posedge clk); #1;
      drive_idle();
      // k counts edges since the first read was accepted
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
`ifdef WRITE_ACK_EN
         exp_v = (k >= 3 && k <= 7);
`else
         exp_v = (k >= 5 && k <= 7);
`endif
         total++;
         if (rsp_valid !== exp_v) begin bad++; $display("FAIL wr_rd_valid k=%0d got=%0b expected=%0b", k, rsp_valid, exp_v); end
         if (k >= 5 && k <= 7) begin
            total++;
            if ({rsp_data, rsp_addr} !== {exp_d[k-5], exp_a[k-5]}) begin
               bad++;
               $display("FAIL wr_rd_data k=%0d got=%0d/%0d expected=%0d/%0d", k, rsp_data, rsp_addr, exp_d[k-5], exp_a[k-5]);
            end
         end
      end
      total++;
      if (credits !== 4'd8) begin bad++; $display("FAIL wr_rd_credits got=%0d expected=8", credits); end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int start_rsp;
      rsp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(acc);
         @(negedge clk);
         if (req_ready) acc++;
      end
      total++;
      if (acc != 8) begin bad++; $display("FAIL bp_accepted got=%0d expected=8", acc); end
      total++;
      if ({req_ready, credits} !== {1'b0, 4'd0}) begin
         bad++; $display("FAIL bp_stall got rdy=%0b credits=%0d expected rdy=0 credits=0", req_ready, credits);
      end
      start_rsp = n_rsp;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         req_valid = (acc < 10); req_addr = 3'(acc);
         @(negedge clk);
         if (req_valid && req_ready) acc++;
         if (acc == 10 && credits == 4'd8 && !req_valid) break;
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      total++;
      if (acc != 10 || n_rsp - start_rsp != 10) begin
         bad++; $display("FAIL bp_drain got acc=%0d rsp=%0d expected acc=10 rsp=10", acc, n_rsp - start_rsp);
      end
   endtask

   task automatic test_pop_accept_at_one();
      int acc = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 20 && acc < 7; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(acc + 2);
         @(negedge clk);
         if (req_ready) acc++;
      end
      @(posedge clk); #1;
      drive_idle();
      repeat (8) @(posedge clk);
      @(negedge clk);
      total++;
      if ({credits, rsp_valid} !== {4'd1, 1'b1}) begin
         bad++; $display("FAIL one_setup got credits=%0d rv=%0b expected credits=1 rv=1", credits, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 3'd1; rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL one_ready_before got=%0b expected=1", req_ready); end
      @(posedge clk); #1;
      drive_idle();
      rsp_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({credits, req_ready} !== {4'd1, 1'b1}) begin
         bad++; $display("FAIL one_after got credits=%0d rdy=%0b expected credits=1 rdy=1", credits, req_ready);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (credits == 4'd8) break;
      end
      total++;
      if (credits !== 4'd8) begin bad++; $display("FAIL one_drain got=%0d expected=8", credits); end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(i);
      end
      @(posedge clk); #1;
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({req_ready, mem_en, rsp_valid, credits} !== {1'b0, 1'b0, 1'b0, 4'd8}) begin
         bad++; $display("FAIL mid_reset got rdy=%0b en=%0b rv=%0b credits=%0d expected 0 0 0 8",
                         req_ready, mem_en, rsp_valid, credits);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL mid_dropped got=%0d responses expected=0", seen); end
      total++;
      if (credits !== 4'd8) begin bad++; $display("FAIL mid_credits got=%0d expected=8", credits); end
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = 3'd1;
      @(posedge clk); #1;
      drive_idle();
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (rsp_valid) begin seen = 1; break; end
      end
      total++;
      if (seen != 1 || {rsp_data, rsp_addr} !== {8'd13, 3'd1}) begin
         bad++; $display("FAIL mid_reread got seen=%0d data=%0d addr=%0d expected seen=1 data=13 addr=1", seen, rsp_data, rsp_addr);
      end
   endtask

   task automatic test_write_ack();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_din = 8'd9;
      @(posedge clk); #1;
      req_we = 1'b0; req_din = '0;
      @(posedge clk); #1;
      drive_idle();
      // k counts edges since the write was accepted
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            total++;
`ifdef WRITE_ACK_EN
            if (credits !== 4'd6) begin bad++; $display("FAIL wa_credits got=%0d expected=6", credits); end
`else
            if (credits !== 4'd7) begin bad++; $display("FAIL wa_credits got=%0d expected=7", credits); end
`endif
         end
`ifdef WRITE_ACK_EN
         if (k == 5) begin
            total++;
            if ({rsp_valid, rsp_we, rsp_addr, rsp_data} !== {1'b1, 1'b1, 3'd2, 8'd0}) begin
               bad++; $display("FAIL wa_ack got rv=%0b we=%0b addr=%0d data=%0d expected 1 1 2 0", rsp_valid, rsp_we, rsp_addr, rsp_data);
            end
         end
`else
         if (k == 5) begin
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wa_posted got rv=%0b expected=0", rsp_valid); end
         end
`endif
         if (k == 6) begin
            total++;
            if ({rsp_valid, rsp_we, rsp_addr, rsp_data} !== {1'b1, 1'b0, 3'd2, 8'd9}) begin
               bad++; $display("FAIL wa_read got rv=%0b we=%0b addr=%0d data=%0d expected 1 0 2 9", rsp_valid, rsp_we, rsp_addr, rsp_data);
            end
         end
      end
   endtask

   task automatic test_random();
      int start_rsp = n_rsp;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         req_valid = ($urandom_range(0, 1) == 1);
         req_we    = ($urandom_range(0, 2) == 0);
         req_addr  = 3'($urandom_range(0, 7));
         req_din   = 8'($urandom_range(0, 255));
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      drive_idle();
      rsp_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && credits == 4'd8) break;
      end
      total++;
      if (sb.size() != 0 || credits !== 4'd8) begin
         bad++; $display("FAIL rand_drain got pending=%0d credits=%0d expected 0 and 8", sb.size(), credits);
      end
      total++;
      if (n_rsp - start_rsp < 100) begin bad++; $display("FAIL rand_activity got=%0d responses expected>=100", n_rsp - start_rsp); end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem_arr[i] = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < int'(RL); i++) dly[i] = '0;
      test_reset();
      test_write_read();
      test_backpressure();
      test_pop_accept_at_one();
      test_reset_midflight();
      test_write_ack();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_req_ctrl.md
Name: mem_port_req_ctrl

Overview:
Single-port request controller that sits directly upstream of one port of the dual-port latency memory. It accepts valid/ready read and write requests and drives the memory port's enable, write-enable, address and data-in. It tracks each read through the fixed READ_LATENCY and buffers returned data in a response FIFO with valid/ready output. A credit counter guarantees that the FIFO never overflows under response backpressure.

Parameters:
WIDTH, 8, data width in bits.
ADDR_WIDTH, 3, address width in bits.
READ_LATENCY, 5, memory port read latency in cycles; must be ≥ 1.
WRITE_LATENCY, 4, memory port write latency in cycles; must be ≤ READ_LATENCY, checked at elaboration.
RSP_DEPTH, 8, response FIFO depth; power of 2; full throughput requires RSP_DEPTH ≥ READ_LATENCY+1.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request ready; equals (credits != 0) and is not dependent on i_req_valid.
i_req_we  in  1  1 = write, 0 = read.
i_req_addr  in  ADDR_WIDTH  request address.
i_req_din  in  WIDTH  write data.
o_mem_en  out  1  memory port enable.
o_mem_we  out  1  memory port write enable.
o_mem_addr  out  ADDR_WIDTH  memory port address.
o_mem_din  out  WIDTH  memory port write data.
i_mem_dout  in  WIDTH  memory port read data.
o_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  response ready.
o_rsp_data  out  WIDTH  read data.
o_rsp_addr  out  ADDR_WIDTH  address tag of the response.
o_rsp_we  out  1  1 = write acknowledge; tied to 0 unless WRITE_ACK_EN is defined.
o_credits  out  $clog2(RSP_DEPTH)+1  free response slots.

Behaviour:
- Accept: accept = i_req_valid & o_req_ready.
- Memory drive: o_mem_en = accept, combinational. o_mem_we, o_mem_addr and o_mem_din pass i_req_* through. The memory samples them at the same edge t.
- All requests stall when credits are 0, writes included.
- Credits:
  - Reset value is RSP_DEPTH.
  - A read accept decrements the count; a response pop (o_rsp_valid & i_rsp_ready) increments it.
  - Both in one cycle leave the count unchanged.
  - The count never exceeds RSP_DEPTH or drops below 0; either would be an assertion failure.
- Read tracking:
  - A shift pipeline of READ_LATENCY stages carries {valid, addr, is_write}.
  - A read accepted at edge t has i_mem_dout valid in the cycle ending at edge t+READ_LATENCY.
  - The FIFO pushes {i_mem_dout, addr, 0} at that edge.
  - Only one request issues per cycle, so there is at most one push per cycle.
- Response FIFO:
  - Synchronous first-word-fall-through.
  - o_rsp_valid = !empty; first response appears in the cycle after edge t+READ_LATENCY.
  - Full-throughput rate is one response per cycle.
  - Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
  - Push to a full FIFO is impossible by the credit rule; assert on it.
  - Pointers wrap modulo RSP_DEPTH.
- Ordering: responses leave in issue order.
- Reset (including mid-operation), all outputs:
  - o_req_ready = 0, o_mem_en = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_din = 0 while i_rst is high.
  - o_rsp_valid = 0, o_rsp_data = 0, o_rsp_addr = 0, o_rsp_we = 0.
  - o_credits = RSP_DEPTH.
  - The pipeline and FIFO are cleared and in-flight reads are dropped.
  - o_req_ready rises in the first cycle after i_rst falls.
- Idle: with i_req_valid = 0, no memory enable is issued.

Optional Feature:
WRITE_ACK_EN
- Defined:
  - A write accept consumes a credit and enters the same READ_LATENCY pipeline with is_write = 1.
  - It pushes {0, addr, 1}, so o_rsp_we = 1 on that response.
  - WRITE_LATENCY ≤ READ_LATENCY guarantees the write has committed when the acknowledge is visible.
- Undefined:
  - Writes are posted and consume no credit.
  - The is_write pipeline bit is removed and o_rsp_we is tied to 0.

Decomposition:
- Package mem_port_pkg holds:
  - default WIDTH/ADDR_WIDTH constants;
  - typedef struct rsp_t {data, addr, we} for FIFO entries;
  - typedef struct pipe_t {valid, addr, is_write} for pipeline stages.
- Sub-module rsp_fifo: parameterised synchronous FWFT FIFO of rsp_t, with push, pop, full, empty and count outputs.

Test Plan:
1. Writes then reads, behavioural memory model, READ_LATENCY = 5, i_rsp_ready = 1: write 12 to address 0, 13 to address 1, then read address 0, address 1, address 0 on consecutive cycles -> o_mem_en high for 5 cycles; responses 12, 13, 12 with o_rsp_addr 0, 1, 0 on consecutive cycles, the first 5 cycles after the first read accept; o_credits returns to 8.
2. Backpressure, i_rsp_ready = 0, 10 back-to-back reads -> 8 accepted, then o_req_ready = 0 with o_credits = 0; after i_rsp_ready = 1, all 8 responses drain in order and the remaining 2 reads are accepted.
3. Simultaneous pop and read accept at credits = 1 -> o_credits stays 1 and o_req_ready stays high.
4. Reset asserted 2 cycles after 3 reads issue -> no response ever appears; o_credits = 8; a following read of address 1 returns 13.
5. WRITE_ACK_EN defined, write 9 to address 2, read address 2 the next cycle -> responses {we = 1, addr 2} then {data 9, addr 2}, each 5 cycles after its accept.
6. Random valid/ready traffic, 2000 cycles, against a scoreboard -> in-order data match, no FIFO overflow assertion, credits within 0..8.
